expr_string_tx: RTL and testbench

//  Transmitter end of the ASCII expression-character stream consumed by the string checker.

---
 rtl/expr_pkg.sv | 20 ++
 rtl/expr_eval_step.sv | 26 ++
 rtl/expr_string_tx.sv | 186 ++++++++++++++++++
 tb/tb_expr_string_tx.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/expr_pkg.sv
// Shared definitions for the expression character stream: ASCII codes and
// the transmitter state encoding, also used by the checker on the receive side.
package expr_pkg;

    localparam logic [7:0] ASCII_0    = 8'h30;
    localparam logic [7:0] ASCII_PLUS = 8'h2B;
    localparam logic [7:0] ASCII_STAR = 8'h2A;

    typedef enum logic [1:0] {
        IDLE,
        DIGIT,
        OP,
        DONE
    } state_t;

    function automatic logic [7:0] digit_char(input logic [3:0] d);
        return ASCII_0 + {4'h0, d};
    endfunction

endpackage

// File: rtl/expr_eval_step.sv
// Combinational sum/term update applied on each accepted character.
// All arithmetic wraps modulo 2**RES_W.
module expr_eval_step #(
    parameter int RES_W = 16
) (
    input  logic [RES_W-1:0] sum,
    input  logic [RES_W-1:0] term,
    input  logic [3:0]       digit,
    input  logic             chain,
    output logic [RES_W-1:0] term_next,
    output logic [RES_W-1:0] sum_add,
    output logic [RES_W-1:0] total
);

    logic [RES_W-1:0] digit_ext;

    // chain means the operator before this operand is '*', so the running
    // product keeps growing instead of starting a new term
    always_comb begin
        digit_ext = RES_W'(digit);
        term_next = chain ? term * digit_ext : digit_ext;
        sum_add   = sum + term;
        total     = sum + term_next;
    end

endmodule

// File: rtl/expr_string_tx.sv
// Streams a digit/operator expression as ASCII over a valid/ready handshake
// and returns its value with '*' binding tighter than '+'.
module expr_string_tx
    import expr_pkg::*;
#(
    parameter  int MAX_OPS = 4,
    parameter  int RES_W   = 16,
    localparam int LEN_W   = $clog2(MAX_OPS + 1),
    localparam int OPS_W   = (MAX_OPS > 1) ? MAX_OPS - 1 : 1
) (
    input  logic                 clk,
    input  logic                 clr,
    input  logic                 start,
    input  logic [LEN_W-1:0]     len,
    input  logic [4*MAX_OPS-1:0] digits,
    input  logic [OPS_W-1:0]     ops,
    input  logic                 ready,
    output logic [7:0]           out_char,
    output logic                 out_valid,
    output logic                 busy,
    output logic                 done,
    output logic [RES_W-1:0]     result,
    output logic                 err
);

    state_t                 state_q, state_d;
    logic [LEN_W-1:0]       idx_q, idx_d;
    logic [LEN_W-1:0]       len_q, len_d;
    logic [4*MAX_OPS-1:0]   digits_q, digits_d;
    logic [OPS_W-1:0]       ops_q, ops_d;
    logic [RES_W-1:0]       sum_q, sum_d;
    logic [RES_W-1:0]       term_q, term_d;
    logic [RES_W-1:0]       result_d;
    logic [7:0]             out_char_d;
    logic                   out_valid_d, busy_d, done_d, err_d;

    logic                   legal;
    logic                   xfer;
    logic                   last;
    logic                   chain;
    logic [LEN_W-1:0]       idx_next;
    logic [3:0]             cur_digit;
    logic [3:0]             next_digit;
    logic [RES_W-1:0]       term_next, sum_add, total;

    always_comb begin
        xfer       = out_valid && ready;
        idx_next   = idx_q + LEN_W'(1);
        last       = (idx_q == len_q - LEN_W'(1));
        cur_digit  = digits_q[4*idx_q +: 4];
        next_digit = digits_q[4*idx_next +: 4];
        chain      = (idx_q != '0) && ops_q[idx_q - LEN_W'(1)];
    end

    // Only operands inside the requested length need to be valid decimal digits
    always_comb begin
        legal = (len != '0) && (len <= LEN_W'(MAX_OPS));
        for (int i = 0; i < MAX_OPS; i++) begin
            if (i < int'(len) && digits[4*i +: 4] > 4'd9) begin
                legal = 1'b0;
            end
        end
    end

    expr_eval_step #(
        .RES_W(RES_W)
    ) u_step (
        .sum       (sum_q),
        .term      (term_q),
        .digit     (cur_digit),
        .chain     (chain),
        .term_next (term_next),
        .sum_add   (sum_add),
        .total     (total)
    );

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        len_d       = len_q;
        digits_d    = digits_q;
        ops_d       = ops_q;
        sum_d       = sum_q;
        term_d      = term_q;
        result_d    = result;
        out_char_d  = out_char;
        out_valid_d = out_valid;
        busy_d      = busy;
        done_d      = 1'b0;
        err_d       = 1'b0;

        case (state_q)
            IDLE: begin
                busy_d      = 1'b0;
                out_valid_d = 1'b0;
                out_char_d  = 8'h00;
                if (start) begin
                    if (legal) begin
                        len_d       = len;
                        digits_d    = digits;
                        ops_d       = ops;
                        idx_d       = '0;
                        sum_d       = '0;
                        term_d      = '0;
                        out_valid_d = 1'b1;
                        out_char_d  = digit_char(digits[3:0]);
                        busy_d      = 1'b1;
                        state_d     = DIGIT;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end

            DIGIT: begin
                if (xfer) begin
                    term_d = term_next;
                    if (last) begin
                        out_valid_d = 1'b0;
                        out_char_d  = 8'h00;
                        result_d    = total;
                        done_d      = 1'b1;
                        state_d     = DONE;
                    end else begin
                        out_char_d = ops_q[idx_q] ? ASCII_STAR : ASCII_PLUS;
                        state_d    = OP;
                    end
                end
            end

            // A '+' closes the current product, so fold it into the sum here
            OP: begin
                if (xfer) begin
                    if (!ops_q[idx_q]) begin
                        sum_d = sum_add;
                    end
                    idx_d      = idx_next;
                    out_char_d = digit_char(next_digit);
                    state_d    = DIGIT;
                end
            end

            DONE: begin
                busy_d  = 1'b0;
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state_q   <= IDLE;
            idx_q     <= '0;
            len_q     <= '0;
            digits_q  <= '0;
            ops_q     <= '0;
            sum_q     <= '0;
            term_q    <= '0;
            result    <= '0;
            out_char  <= 8'h00;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            len_q     <= len_d;
            digits_q  <= digits_d;
            ops_q     <= ops_d;
            sum_q     <= sum_d;
            term_q    <= term_d;
            result    <= result_d;
            out_char  <= out_char_d;
            out_valid <= out_valid_d;
            busy      <= busy_d;
            done      <= done_d;
            err       <= err_d;
        end
    end

endmodule

// File: tb/tb_expr_string_tx.sv
// Self-checking bench for expr_string_tx: a 16-bit and an 8-bit result instance
// share one stimulus stream and are checked against a value/string model.
module tb_expr_string_tx;

    logic        clk = 1'b0;
    logic        clr = 1'b1;
    logic        start = 1'b0;
    logic [2:0]  len = '0;
    logic [15:0] digits = '0;
    logic [2:0]  ops = '0;
    logic        ready = 1'b0;

    logic [7:0]  out_char, out_char8;
    logic        out_valid, out_valid8;
    logic        busy, busy8;
    logic        done, done8;
    logic        err, err8;
    logic [15:0] result;
    logic [7:0]  result8;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    expr_string_tx #(.MAX_OPS(4), .RES_W(16)) dut (
        .clk(clk), .clr(clr), .start(start), .len(len), .digits(digits), .ops(ops),
        .ready(ready), .out_char(out_char), .out_valid(out_valid), .busy(busy),
        .done(done), .result(result), .err(err)
    );

    expr_string_tx #(.MAX_OPS(4), .RES_W(8)) dut8 (
        .clk(clk), .clr(clr), .start(start), .len(len), .digits(digits), .ops(ops),
        .ready(ready), .out_char(out_char8), .out_valid(out_valid8), .busy(busy8),
        .done(done8), .result(result8), .err(err8)
    );

    typedef struct {
        int          n;
        logic [15:0] dg;
        logic [2:0]  op;
        int          mode;
        bit          exp_err;
        string       exp_str;
        int          exp_val;
    } vec_t;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic check_str(input string name, input string act, input string exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got \"%s\", expected \"%s\"", name, act, exp);
        end
    endtask

    function automatic logic [15:0] pack4(input int a, input int b, input int c, input int d);
        return {d[3:0], c[3:0], b[3:0], a[3:0]};
    endfunction

    // Value as a list of products: '*' extends the last product, '+' opens a new one
    function automatic int model_value(input int n, input logic [15:0] dg, input logic [2:0] op);
        int terms[$];
        int total = 0;
        terms.push_back(int'(dg[3:0]));
        for (int i = 1; i < n; i++) begin
            if (op[i-1]) terms[$] = terms[$] * int'(dg[4*i +: 4]);
            else         terms.push_back(int'(dg[4*i +: 4]));
        end
        foreach (terms[k]) total += terms[k];
        return total;
    endfunction

    function automatic string model_string(input int n, input logic [15:0] dg, input logic [2:0] op);
        string s = "";
        for (int i = 0; i < n; i++) begin
            s = {s, $sformatf("%0d", dg[4*i +: 4])};
            if (i < n - 1) s = {s, op[i] ? "*" : "+"};
        end
        return s;
    endfunction

    // mode 0: ready always high; 1: ready low for 2 cycles on the first '+'; 2: random ready
    task automatic run_expr(input vec_t v, input string tag);
        string got = "";
        int    cycles = 0;
        int    plus_hold;
        bit    zero_bad = 0, busy_bad = 0, stable_bad = 0, twin_bad = 0;
        bit    held = 0;
        logic  [7:0] held_char = '0;
        logic  r;

        plus_hold = (v.mode == 1) ? 2 : 0;
        start  = 1'b1;
        len    = v.n[2:0];
        digits = v.dg;
        ops    = v.op;
        ready  = 1'b1;
        tick();
        check({tag, ".first_valid"}, {31'b0, out_valid}, 32'd1);
        while (cycles < 64 && done !== 1'b1) begin
            start  = 1'($urandom_range(0, 1));
            len    = 3'($urandom);
            digits = 16'($urandom);
            ops    = 3'($urandom);
            if (out_valid !== 1'b1 && out_char !== 8'h00) zero_bad = 1;
            if (busy !== 1'b1) busy_bad = 1;
            if (held && out_char !== held_char) stable_bad = 1;
            if (out_char8 !== out_char || out_valid8 !== out_valid || busy8 !== busy || done8 !== done)
                twin_bad = 1;
            case (v.mode)
                0: r = 1'b1;
                1: begin
                    r = 1'b1;
                    if (out_valid === 1'b1 && out_char == 8'h2B && plus_hold > 0) begin
                        r = 1'b0;
                        plus_hold--;
                    end
                end
                default: r = 1'($urandom_range(0, 1));
            endcase
            ready = r;
            if (out_valid === 1'b1 && r) got = {got, $sformatf("%c", out_char)};
            held      = (out_valid === 1'b1) && !r;
            held_char = out_char;
            tick();
            cycles++;
        end
        start = 1'b0;
        check({tag, ".done_seen"}, {31'b0, done}, 32'd1);
        check_str({tag, ".chars"}, got, v.exp_str);
        check({tag, ".result16"}, {16'b0, result}, 32'(v.exp_val % 65536));
        check({tag, ".result8"}, {24'b0, result8}, 32'(v.exp_val % 256));
        check({tag, ".done_busy"}, {31'b0, busy}, 32'd1);
        check({tag, ".done_novalid"}, {31'b0, out_valid}, 32'd0);
        if (v.mode == 0) check({tag, ".cycles"}, 32'(cycles), 32'(2 * v.n - 1));
        if (v.mode == 1) check({tag, ".cycles_held"}, 32'(cycles), 32'(2 * v.n + 1));
        check({tag, ".zero_char"}, {31'b0, zero_bad}, 32'd0);
        check({tag, ".busy_stream"}, {31'b0, busy_bad}, 32'd0);
        check({tag, ".stable"}, {31'b0, stable_bad}, 32'd0);
        check({tag, ".twin"}, {31'b0, twin_bad}, 32'd0);
        tick();
        check({tag, ".done_pulse"}, {31'b0, done}, 32'd0);
        check({tag, ".idle_busy"}, {31'b0, busy}, 32'd0);
        check({tag, ".idle_valid"}, {31'b0, out_valid}, 32'd0);
        check({tag, ".result_held"}, {16'b0, result}, 32'(v.exp_val % 65536));
    endtask

    task automatic apply_err(input vec_t v, input string tag);
        start  = 1'b1;
        len    = v.n[2:0];
        digits = v.dg;
        ops    = v.op;
        tick();
        start = 1'b0;
        check({tag, ".err"}, {31'b0, err}, 32'd1);
        check({tag, ".err8"}, {31'b0, err8}, 32'd1);
        check({tag, ".err_valid"}, {31'b0, out_valid}, 32'd0);
        check({tag, ".err_busy"}, {31'b0, busy}, 32'd0);
        tick();
        check({tag, ".err_pulse"}, {31'b0, err}, 32'd0);
        check({tag, ".err_valid2"}, {31'b0, out_valid}, 32'd0);
        check({tag, ".err_busy2"}, {31'b0, busy}, 32'd0);
    endtask

    vec_t table_v[$];
    vec_t v;

    initial begin
        table_v.push_back('{3, pack4(3, 5, 9, 0),   3'b010, 0, 1'b0, "3+5*9",   48});
        table_v.push_back('{3, pack4(3, 5, 9, 0),   3'b010, 1, 1'b0, "3+5*9",   48});
        table_v.push_back('{1, pack4(7, 0, 0, 0),   3'b000, 0, 1'b0, "7",       7});
        table_v.push_back('{4, pack4(9, 9, 9, 9),   3'b111, 0, 1'b0, "9*9*9*9", 6561});
        table_v.push_back('{4, pack4(9, 9, 9, 9),   3'b000, 0, 1'b0, "9+9+9+9", 36});
        table_v.push_back('{2, pack4(3, 4, 15, 15), 3'b001, 0, 1'b0, "3*4",     12});
        table_v.push_back('{4, pack4(2, 0, 8, 1),   3'b101, 0, 1'b0, "2*0+8*1", 8});
        table_v.push_back('{4, pack4(6, 7, 8, 9),   3'b010, 2, 1'b0, "6+7*8+9", 71});
        table_v.push_back('{0, pack4(1, 2, 3, 4),   3'b000, 0, 1'b1, "",        0});
        table_v.push_back('{3, pack4(1, 12, 3, 0),  3'b000, 0, 1'b1, "",        0});
        table_v.push_back('{5, pack4(1, 2, 3, 4),   3'b000, 0, 1'b1, "",        0});
        table_v.push_back('{4, pack4(1, 2, 3, 10),  3'b011, 0, 1'b1, "",        0});

        #1;
        check("reset.out_valid", {31'b0, out_valid}, 32'd0);
        check("reset.out_char", {24'b0, out_char}, 32'd0);
        check("reset.busy", {31'b0, busy}, 32'd0);
        check("reset.done", {31'b0, done}, 32'd0);
        check("reset.err", {31'b0, err}, 32'd0);
        check("reset.result", {16'b0, result}, 32'd0);
        check("reset.result8", {24'b0, result8}, 32'd0);
        tick();
        tick();
        clr = 1'b0;
        tick();

        for (int i = 0; i < table_v.size(); i++) begin
            if (table_v[i].exp_err) apply_err(table_v[i], $sformatf("vec%0d", i));
            else                    run_expr(table_v[i], $sformatf("vec%0d", i));
        end

        for (int i = 0; i < 30; i++) begin
            v.n    = $urandom_range(1, 4);
            v.dg   = pack4($urandom_range(0, 9), $urandom_range(0, 9),
                           $urandom_range(0, 9), $urandom_range(0, 9));
            v.op   = 3'($urandom);
            v.mode = 2;
            v.exp_err = 1'b0;
            v.exp_str = model_string(v.n, v.dg, v.op);
            v.exp_val = model_value(v.n, v.dg, v.op);
            run_expr(v, $sformatf("rnd%0d", i));
        end

        // Abort mid-stream after "3+" has been accepted
        start  = 1'b1;
        len    = 3'd3;
        digits = pack4(3, 5, 9, 0);
        ops    = 3'b010;
        ready  = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        check("clr.pre_char", {24'b0, out_char}, 32'h35);
        #2 clr = 1'b1;
        #1;
        check("clr.valid", {31'b0, out_valid}, 32'd0);
        check("clr.busy", {31'b0, busy}, 32'd0);
        check("clr.result", {16'b0, result}, 32'd0);
        check("clr.char", {24'b0, out_char}, 32'd0);
        tick();
        clr = 1'b0;
        tick();
        check("clr.no_done", {31'b0, done}, 32'd0);
        check("clr.stays_idle", {31'b0, out_valid}, 32'd0);
        run_expr(table_v[0], "after_clr");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
